// File: rtl/data_mem_pkg.sv
// Shared constants for the data-memory arbiter: address regions, access size codes, FSM states.
package data_mem_pkg;

  localparam logic [15:0] REGION_DATA  = 16'h1000;
  localparam logic [15:0] REGION_STACK = 16'h7fff;
  localparam logic [15:0] REGION_MMIO  = 16'hffff;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Mapped region, valid size code and natural alignment; anything else is rejected.
  function automatic logic access_legal(input logic [15:0] region, input logic [1:0] low,
                                        input logic [1:0] size);
    logic mapped;
    logic aligned;
    mapped  = (region == REGION_DATA) || (region == REGION_STACK) || (region == REGION_MMIO);
    aligned = 1'b0;
    case (size)
      SZ_BYTE: aligned = 1'b1;
      SZ_HALF: aligned = (low[0] == 1'b0);
      SZ_WORD: aligned = (low == 2'b00);
      default: aligned = 1'b0;
    endcase
    return mapped && aligned;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of both requester ports plus the data_memory port; master = requesters/memory, slave = arbiter.
interface data_mem_arbiter_if;
  logic        req0, req1;
  logic        we0, we1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  size0, size1;
  logic        sign0, sign1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic        err0, err1;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
           size0, size1, sign0, sign1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, err0, err1,
           mem_addr, mem_wdata, mem_re, mem_we, mem_size
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
           size0, size1, sign0, sign1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, err0, err1,
           mem_addr, mem_wdata, mem_re, mem_we, mem_size
  );
endinterface

// File: rtl/data_mem_arbiter_load_lane_extract.sv
// Picks the addressed byte/half out of a big-endian word and zero- or sign-extends it to 32 bits.
module load_lane_extract
  import data_mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_sign,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_offset)
      2'd0: w_byte = i_word[31:24];
      2'd1: w_byte = i_word[23:16];
      2'd2: w_byte = i_word[15:8];
      2'd3: w_byte = i_word[7:0];
      default: w_byte = 8'h00;
    endcase
    w_half = i_offset[1] ? i_word[15:0] : i_word[31:16];

    o_result = i_word;
    case (i_size)
      SZ_BYTE: o_result = {{24{i_sign & w_byte[7]}}, w_byte};
      SZ_HALF: o_result = {{16{i_sign & w_half[15]}}, w_half};
      default: o_result = i_word;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single data_memory port: one checked access per grant, registered response.
//   state    | meaning
//   ST_IDLE  | sample requests, grant, latch fields and pre-load mem_* for the access
//   ST_ISSUE | mem_re/mem_we asserted for one cycle (legal accesses only); load data captured
//   ST_RESP  | ack strobe to the granted port with registered rdata/err
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input logic               i_clock,
  input logic               i_reset,
  data_mem_arbiter_if.slave io_bus
);

  state_t      r_state;
  logic        r_port, r_last_grant, r_we, r_sign, r_legal;
  logic [1:0]  r_off, r_size;
  logic        r_ack0, r_ack1, r_err0, r_err1;
  logic [31:0] r_rdata0, r_rdata1;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic        r_mem_re, r_mem_we;
  logic [1:0]  r_mem_size;

  logic        w_any, w_grant1, w_sel_we, w_sel_sign, w_legal;
  logic [31:0] w_sel_addr, w_sel_wdata, w_load_data, w_resp_data;
  logic [1:0]  w_sel_size;

  assign w_any = io_bus.req0 | io_bus.req1;

  always_comb begin
    w_grant1 = io_bus.req1;
    if (io_bus.req0 && io_bus.req1)
      w_grant1 = FIXED_PRIO ? 1'b0 : ~r_last_grant;
  end

  assign w_sel_we    = w_grant1 ? io_bus.we1    : io_bus.we0;
  assign w_sel_addr  = w_grant1 ? io_bus.addr1  : io_bus.addr0;
  assign w_sel_wdata = w_grant1 ? io_bus.wdata1 : io_bus.wdata0;
  assign w_sel_size  = w_grant1 ? io_bus.size1  : io_bus.size0;
  assign w_sel_sign  = w_grant1 ? io_bus.sign1  : io_bus.sign0;
  assign w_legal     = access_legal(w_sel_addr[31:16], w_sel_addr[1:0], w_sel_size);

  load_lane_extract u_lane (
    .i_word   (io_bus.mem_rdata),
    .i_offset (r_off),
    .i_size   (r_size),
    .i_sign   (r_sign),
    .o_result (w_load_data)
  );

  // Stores and rejected accesses return zero data.
  assign w_resp_data = (r_legal && !r_we) ? w_load_data : 32'h0;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_port       <= 1'b0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_sign       <= 1'b0;
      r_legal      <= 1'b0;
      r_off        <= 2'b00;
      r_size       <= 2'b00;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_rdata0     <= 32'h0;
      r_rdata1     <= 32'h0;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_size   <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_port       <= w_grant1;
            r_last_grant <= w_grant1;
            r_we         <= w_sel_we;
            r_sign       <= w_sel_sign;
            r_off        <= w_sel_addr[1:0];
            r_size       <= w_sel_size;
            r_legal      <= w_legal;
            if (w_legal) begin
              if (w_sel_we) begin
                r_mem_we    <= 1'b1;
                r_mem_size  <= w_sel_size;
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
              end else begin
                r_mem_re   <= 1'b1;
                r_mem_size <= SZ_WORD;
                r_mem_addr <= {w_sel_addr[31:2], 2'b00};
              end
            end
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_mem_re <= 1'b0;
          r_mem_we <= 1'b0;
          if (r_port) begin
            r_ack1   <= 1'b1;
            r_err1   <= ~r_legal;
            r_rdata1 <= w_resp_data;
          end else begin
            r_ack0   <= 1'b1;
            r_err0   <= ~r_legal;
            r_rdata0 <= w_resp_data;
          end
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.ack0      = r_ack0;
  assign io_bus.ack1      = r_ack1;
  assign io_bus.err0      = r_err0;
  assign io_bus.err1      = r_err1;
  assign io_bus.rdata0    = r_rdata0;
  assign io_bus.rdata1    = r_rdata1;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;
  assign io_bus.mem_re    = r_mem_re;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_size  = r_mem_size;

endmodule
